// File: rtl/perif_uart_pkg.sv
// rtl/perif_uart_pkg.sv - shared UART frame constants and FSM state type
package perif_uart_pkg;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_start = 2'd1,
    st_data  = 2'd2,
    st_stop  = 2'd3
  } uart_state_t;

  localparam int c_data_bits = 8;
  localparam int c_stop_bits = 1;

  // A zero baud setting still needs a one-cycle bit.
  function automatic logic [15:0] bit_period(input logic [15:0] baud);
    return (baud == 16'd0) ? 16'd1 : baud;
  endfunction

endpackage

// File: rtl/perif_uart_tx_if.sv
// rtl/perif_uart_tx_if.sv - byte write strobe and transmit FIFO status
interface perif_uart_tx_if;

  logic       i_wr_en;
  logic [7:0] i_wr_data;
  logic       o_full;
  logic       o_empty;

  modport master (output i_wr_en, i_wr_data, input o_full, o_empty);
  modport slave  (input i_wr_en, i_wr_data, output o_full, o_empty);

endinterface

// File: rtl/perif_uart_fifo.sv
// rtl/perif_uart_fifo.sv - power-of-two byte FIFO shared by UART tx and rx
module perif_uart_fifo #(
  parameter int p_depth = 4,
  parameter int p_width = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [p_width-1:0]         i_data,
  input  logic                       i_pop,
  output logic [p_width-1:0]         o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(p_depth):0]   o_count
);

  localparam int c_aw = $clog2(p_depth);
  localparam logic [c_aw:0] c_full_count = (c_aw + 1)'(p_depth);

  logic [p_width-1:0] mem [p_depth];
  logic [c_aw-1:0]    wr_ptr;
  logic [c_aw-1:0]    rd_ptr;
  logic [c_aw:0]      count;
  logic               do_push;
  logic               do_pop;

  // A push into a full FIFO is dropped even when a pop happens in the same cycle.
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  assign o_full  = (count == c_full_count);
  assign o_empty = (count == '0);
  assign o_count = count;
  assign o_data  = mem[rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

endmodule

// File: rtl/perif_uart_tx.sv
// rtl/perif_uart_tx.sv - buffered 8N1 UART transmitter
module perif_uart_tx
  import perif_uart_pkg::*;
#(
  parameter int p_fifo_depth = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_en,
  input  logic [15:0]    i_baudrate,
  perif_uart_tx_if.slave wr_bus,
  output logic           o_tx_bit,
  output logic           o_busy
);

  localparam int         c_cw        = $clog2(p_fifo_depth) + 1;
  localparam logic [2:0] c_last_data = 3'(c_data_bits - 1);
  localparam logic [2:0] c_last_stop = 3'(c_stop_bits - 1);

  uart_state_t     state, state_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [15:0]     baud_cnt, baud_cnt_n;
  logic [7:0]      shift, shift_n;
  logic            tx_n;
  logic            bit_done;
  logic            fifo_pop;
  logic [7:0]      fifo_data;
  logic [c_cw-1:0] fifo_count;

  perif_uart_fifo #(
    .p_depth (p_fifo_depth),
    .p_width (8)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (wr_bus.i_wr_en),
    .i_data  (wr_bus.i_wr_data),
    .i_pop   (fifo_pop),
    .o_data  (fifo_data),
    .o_full  (wr_bus.o_full),
    .o_empty (wr_bus.o_empty),
    .o_count (fifo_count)
  );

  // >= rather than == so a baud rate lowered mid-bit ends that bit at once.
  assign bit_done = (baud_cnt >= bit_period(i_baudrate) - 16'd1);
  assign o_busy   = (state != st_idle);

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    baud_cnt_n = baud_cnt;
    shift_n    = shift;
    fifo_pop   = 1'b0;
    tx_n       = 1'b1;

    if (!i_en) begin
      state_n    = st_idle;
      bit_cnt_n  = '0;
      baud_cnt_n = '0;
    end else begin
      case (state)
        st_idle: begin
          if (fifo_count != '0) begin
            fifo_pop   = 1'b1;
            shift_n    = fifo_data;
            bit_cnt_n  = '0;
            baud_cnt_n = '0;
            state_n    = st_start;
          end
        end
        st_start: begin
          if (bit_done) begin
            baud_cnt_n = '0;
            state_n    = st_data;
          end else begin
            baud_cnt_n = baud_cnt + 16'd1;
          end
        end
        st_data: begin
          if (bit_done) begin
            baud_cnt_n = '0;
            if (bit_cnt == c_last_data) begin
              bit_cnt_n = '0;
              state_n   = st_stop;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt_n = baud_cnt + 16'd1;
          end
        end
        st_stop: begin
          if (bit_done) begin
            baud_cnt_n = '0;
            if (bit_cnt == c_last_stop) begin
              bit_cnt_n = '0;
              state_n   = st_idle;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt_n = baud_cnt + 16'd1;
          end
        end
        default: state_n = st_idle;
      endcase
    end

    // Line level is registered from the next state so it changes with the state.
    case (state_n)
      st_start: tx_n = 1'b0;
      st_data:  tx_n = shift_n[bit_cnt_n];
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= st_idle;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shift    <= '0;
      o_tx_bit <= 1'b1;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      baud_cnt <= baud_cnt_n;
      shift    <= shift_n;
      o_tx_bit <= tx_n;
    end
  end

endmodule

// File: tb/tb_perif_uart_tx.sv
// tb/tb_perif_uart_tx.sv - scoreboard bench for the buffered UART transmitter
module tb_perif_uart_tx;

  localparam int c_depth = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic [15:0] i_baudrate;
  logic        o_tx_bit;
  logic        o_busy;

  perif_uart_tx_if wr();

  perif_uart_tx #(.p_fifo_depth(c_depth)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_baudrate (i_baudrate),
    .wr_bus     (wr),
    .o_tx_bit   (o_tx_bit),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int         busy_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a frame occupies the line for 10 bit periods after the
  // byte is taken, and the transmitter takes a new byte only after one idle cycle.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fq.delete();
      exp_q.delete();
      busy_left = 0;
    end else begin
      int  sz;
      bit  do_push;
      sz      = fq.size();
      do_push = wr.i_wr_en && (sz < c_depth);
      if (!i_en) begin
        if (busy_left > 0 && exp_q.size() > 0) void'(exp_q.pop_front());
        busy_left = 0;
      end else if (busy_left == 0 && sz > 0) begin
        exp_q.push_back(fq.pop_front());
        busy_left = 10 * ((i_baudrate == 16'd0) ? 1 : int'(i_baudrate));
      end else if (busy_left > 0) begin
        busy_left--;
      end
      if (do_push) fq.push_back(wr.i_wr_data);
    end
  end

  initial begin : status_monitor
    forever begin
      @(negedge i_clk);
      check("busy", 32'(o_busy), 32'(busy_left > 0));
      check("empty", 32'(wr.o_empty), 32'(fq.size() == 0));
      check("full", 32'(wr.o_full), 32'(fq.size() == c_depth));
    end
  end

  task automatic wait_n(input int n, inout bit ok);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      if (i_rst || !i_en) ok = 1'b0;
    end
  endtask

  // Serial receiver: samples each bit at its centre and checks against the queue.
  initial begin : line_monitor
    forever begin
      @(negedge i_clk);
      if (!i_rst && i_en && o_tx_bit === 1'b0) begin
        int         p;
        bit         ok;
        logic [9:0] frame;
        ok = 1'b1;
        p  = (i_baudrate == 16'd0) ? 1 : int'(i_baudrate);
        wait_n(p / 2, ok);
        frame[0] = o_tx_bit;
        for (int k = 1; k < 10; k++) begin
          if (ok) begin
            wait_n(p, ok);
            frame[k] = o_tx_bit;
          end
        end
        if (ok) begin
          n_frames++;
          check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            check("frame_data", 32'(frame[8:1]), 32'(exp_q.pop_front()));
            check("frame_start", 32'(frame[0]), 32'd0);
            check("frame_stop", 32'(frame[9]), 32'd1);
          end
        end
      end
    end
  end

  task automatic write_byte(input logic [7:0] b);
    @(negedge i_clk); #1;
    wr.i_wr_en   = 1'b1;
    wr.i_wr_data = b;
    @(negedge i_clk); #1;
    wr.i_wr_en   = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fq.size() != 0 || busy_left != 0) && n < 30000) begin
      @(negedge i_clk);
      n++;
    end
    check({name, "_drain_timeout"}, 32'(n >= 30000), 32'd0);
    repeat (3) @(negedge i_clk);
  endtask

  // Checks the exact line waveform of one frame starting two cycles after the write.
  task automatic frame_wave(input string name, input logic [7:0] b, input int p);
    int errs;
    int busy_cycles;
    int k;
    logic exp_bit;
    errs = 0;
    busy_cycles = 0;
    write_byte(b);
    check({name, "_line_before_start"}, 32'(o_tx_bit), 32'd1);
    for (int i = 0; i < 10 * p + 2; i++) begin
      @(negedge i_clk);
      k = i / p;
      if (k == 0)      exp_bit = 1'b0;
      else if (k < 9)  exp_bit = b[k-1];
      else             exp_bit = 1'b1;
      if (o_tx_bit !== exp_bit) errs++;
      if (o_busy === 1'b1) busy_cycles++;
    end
    check({name, "_wave_errors"}, 32'(errs), 32'd0);
    check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(10 * p));
  endtask

  initial begin : stimulus
    int f0;
    int quiet;
    i_rst        = 1'b1;
    i_en         = 1'b0;
    i_baudrate   = 16'd4;
    wr.i_wr_en   = 1'b0;
    wr.i_wr_data = 8'h00;

    @(negedge i_clk);
    check("reset_tx", 32'(o_tx_bit), 32'd1);
    check("reset_empty", 32'(wr.o_empty), 32'd1);
    check("reset_full", 32'(wr.o_full), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    #1;
    i_rst = 1'b0;
    i_en  = 1'b1;
    repeat (2) @(negedge i_clk);

    frame_wave("a5_baud4", 8'hA5, 4);
    drain("a5");

    #1 i_baudrate = 16'd0;
    frame_wave("ff_baud0", 8'hFF, 1);
    drain("ff");

    // Back-to-back burst into a depth-4 FIFO; the sixth byte lands on a full FIFO.
    #1 i_baudrate = 16'd2;
    f0 = n_frames;
    for (int v = 1; v <= 6; v++) begin
      @(negedge i_clk);
      if (v == 6) check("burst_full_after_5th", 32'(wr.o_full), 32'd1);
      #1;
      wr.i_wr_en   = 1'b1;
      wr.i_wr_data = 8'(v);
    end
    @(negedge i_clk); #1;
    wr.i_wr_en = 1'b0;
    drain("burst");
    check("burst_frames", 32'(n_frames - f0), 32'd5);

    // Abort mid data bits, then send a byte queued while disabled.
    #1 i_baudrate = 16'd4;
    write_byte(8'h3C);
    repeat (14) @(negedge i_clk);
    #1 i_en = 1'b0;
    @(negedge i_clk);
    check("abort_tx_high", 32'(o_tx_bit), 32'd1);
    check("abort_not_busy", 32'(o_busy), 32'd0);
    write_byte(8'h55);
    repeat (5) @(negedge i_clk);
    check("disabled_tx_high", 32'(o_tx_bit), 32'd1);
    check("disabled_queued", 32'(wr.o_empty), 32'd0);
    f0 = n_frames;
    #1 i_en = 1'b1;
    drain("after_abort");
    check("after_abort_frames", 32'(n_frames - f0), 32'd1);

    // Asynchronous reset mid-frame with three bytes still queued.
    for (int v = 0; v < 4; v++) begin
      @(negedge i_clk); #1;
      wr.i_wr_en   = 1'b1;
      wr.i_wr_data = 8'h90 + 8'(v);
    end
    @(negedge i_clk); #1;
    wr.i_wr_en = 1'b0;
    repeat (8) @(negedge i_clk);
    #3 i_rst = 1'b1;
    #1;
    check("rst_async_tx", 32'(o_tx_bit), 32'd1);
    check("rst_async_empty", 32'(wr.o_empty), 32'd1);
    check("rst_async_busy", 32'(o_busy), 32'd0);
    @(negedge i_clk); #1;
    i_rst = 1'b0;
    quiet = 0;
    f0 = n_frames;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_tx_bit === 1'b1) quiet++;
    end
    check("rst_line_quiet", 32'(quiet), 32'd100);
    check("rst_no_frames", 32'(n_frames - f0), 32'd0);

    // Random bytes at a slow rate, as a receiver loopback would see them.
    #1 i_baudrate = 16'd16;
    f0 = n_frames;
    for (int i = 0; i < 32; i++) begin
      write_byte(8'($urandom));
      repeat ($urandom_range(0, 200)) @(negedge i_clk);
    end
    drain("rand16");
    check("rand16_frames_seen", 32'(n_frames - f0 > 0), 32'd1);

    // Random bytes at fast rates with tight gaps so some writes hit a full FIFO.
    #1 i_baudrate = 16'($urandom_range(1, 3));
    for (int i = 0; i < 24; i++) begin
      @(negedge i_clk); #1;
      wr.i_wr_en   = 1'b1;
      wr.i_wr_data = 8'($urandom);
      @(negedge i_clk); #1;
      wr.i_wr_en = 1'b0;
      repeat ($urandom_range(0, 12)) @(negedge i_clk);
    end
    drain("rand_fast");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #(900000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
